// File: rtl/e_mdu.sv
// e_mdu: multi-cycle multiply/divide unit for the Execute stage. It owns HI/LO and stalls D through `busy`.
// Optional MADD/MADDU accumulate support is enabled by defining MDU_MADD_EN.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8
   } op_t;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [63:0] res_q, res_d;
   logic        commit_q, commit_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;

   // Products are computed on the operands of the start cycle only.
   logic [63:0] prod_s;
   logic [63:0] prod_u;

   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'b0, A} * {32'b0, B};

   // Signed division goes through one unsigned divider on operand magnitudes;
   // the quotient takes the XOR of the signs, the remainder the sign of A.
   // 0x80000000 / -1 falls out naturally: the magnitude 2^31 negates back to 0x80000000.
   logic        is_sdiv;
   logic [31:0] div_n, div_d;
   logic [31:0] uquo, urem;
   logic [31:0] quo, rem;

   assign is_sdiv = (op == OP_DIV);
   assign div_n   = (is_sdiv && A[31]) ? -A : A;
   assign div_d   = (is_sdiv && B[31]) ? -B : B;
   assign uquo    = (B == 32'd0) ? 32'd0 : div_n / div_d;
   assign urem    = (B == 32'd0) ? 32'd0 : div_n % div_d;
   assign quo     = (is_sdiv && (A[31] ^ B[31])) ? -uquo : uquo;
   assign rem     = (is_sdiv && A[31]) ? -urem : urem;

`ifdef MDU_MADD_EN
   // HI/LO cannot change while RUN, so accumulating against the start-time value is exact.
   logic [63:0] acc;
   assign acc = {hi_q, lo_q} + ((op == OP_MADD) ? prod_s : prod_u);
`endif

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      res_d    = res_q;
      commit_d = commit_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               case (op)
                  OP_MULT: begin
                     res_d    = prod_s;
                     commit_d = 1'b1;
                     cnt_d    = 8'(MULT_CYCLES);
                     state_d  = RUN;
                  end
                  OP_MULTU: begin
                     res_d    = prod_u;
                     commit_d = 1'b1;
                     cnt_d    = 8'(MULT_CYCLES);
                     state_d  = RUN;
                  end
                  OP_DIV, OP_DIVU: begin
                     // Divide by zero still occupies the unit but never writes HI/LO.
                     res_d    = {rem, quo};
                     commit_d = (B != 32'd0);
                     cnt_d    = 8'(DIV_CYCLES);
                     state_d  = RUN;
                  end
                  OP_MTHI: hi_d = A;
                  OP_MTLO: lo_d = A;
`ifdef MDU_MADD_EN
                  OP_MADD, OP_MADDU: begin
                     res_d    = acc;
                     commit_d = 1'b1;
                     cnt_d    = 8'(MULT_CYCLES);
                     state_d  = RUN;
                  end
`endif
                  default: ;
               endcase
            end
         end
         RUN: begin
            if (cnt_q == 8'd1) begin
               if (commit_q) begin
                  hi_d = res_q[63:32];
                  lo_d = res_q[31:0];
               end
               cnt_d    = 8'd0;
               commit_d = 1'b0;
               state_d  = IDLE;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: the result register is reset as well, so nothing from a discarded operation survives.
         state_q  <= IDLE;
         cnt_q    <= 8'd0;
         res_q    <= 64'd0;
         commit_q <= 1'b0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
      end else begin
         // NOTE: state updates are non-blocking so every flop samples pre-edge values.
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         res_q    <= res_d;
         commit_q <= commit_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy = (state_q == RUN);
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Directed, scoreboard-based testbench for e_mdu (default MULT_CYCLES=5, DIV_CYCLES=10).
// Build with +define+MDU_MADD_EN to exercise the MADD/MADDU path.
module tb_e_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] A, B;
   logic        busy;
   logic [31:0] hi, lo;

   int passed = 0;
   int total  = 0;

   typedef struct {
      string       tag;
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t sb[$];

   e_mdu dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .A     (A),
      .B     (B),
      .busy  (busy),
      .hi    (hi),
      .lo    (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic expect_result(input string tag, input logic [31:0] h, input logic [31:0] l,
                                input int cycles);
      exp_t e;
      e.tag    = tag;
      e.hi     = h;
      e.lo     = l;
      e.cycles = cycles;
      sb.push_back(e);
   endtask

   // Called at a negedge; holds start for one cycle and returns at the next negedge.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      A     = a;
      B     = b;
      @(negedge clk);
      start = 1'b0;
      op    = 4'd0;
   endtask

   // Counts remaining busy cycles (bounded), then compares against the oldest expectation.
   task automatic wait_done();
      exp_t e;
      int   n = 0;
      check("scoreboard not empty", 64'(sb.size() > 0), 64'd1);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         while (busy === 1'b1 && n < 400) begin
            n++;
            @(negedge clk);
         end
         check({e.tag, " busy cycles"}, 64'(n), 64'(e.cycles));
         check({e.tag, " hi"}, 64'(hi), 64'(e.hi));
         check({e.tag, " lo"}, 64'(lo), 64'(e.lo));
      end
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      op    = 4'd0;
      A     = 32'd0;
      B     = 32'd0;
      @(negedge clk);
      check("reset hi", 64'(hi), 64'd0);
      check("reset lo", 64'(lo), 64'd0);
      check("reset busy", 64'(busy), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      expect_result("mult -2*3", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5);
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      wait_done();

      expect_result("multu fffffffe*3", 32'h0000_0002, 32'hFFFF_FFFA, 5);
      issue(4'd2, 32'hFFFF_FFFE, 32'd3);
      wait_done();

      expect_result("multu max*max", 32'hFFFF_FFFE, 32'h0000_0001, 5);
      issue(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done();

      expect_result("div -7/2", 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done();

      expect_result("div -7/-2", 32'hFFFF_FFFF, 32'h0000_0003, 10);
      issue(4'd3, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
      wait_done();

      expect_result("div min/-1", 32'h0000_0000, 32'h8000_0000, 10);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done();

      expect_result("divu 100/7", 32'd2, 32'd14, 10);
      issue(4'd4, 32'd100, 32'd7);
      wait_done();

      issue(4'd5, 32'h0000_1234, 32'd0);
      check("mthi hi", 64'(hi), 64'h1234);
      check("mthi lo untouched", 64'(lo), 64'd14);
      check("mthi busy", 64'(busy), 64'd0);

      issue(4'd5, 32'h11, 32'd0);
      issue(4'd6, 32'h22, 32'd0);
      check("mtlo lo", 64'(lo), 64'h22);
      expect_result("divu by zero", 32'h11, 32'h22, 10);
      issue(4'd4, 32'd7, 32'd0);
      wait_done();

      // A DIV start one cycle into a MULT must be dropped; one busy cycle is already consumed.
      expect_result("mult with ignored div", 32'hFFFF_FFFF, 32'hFFFF_FFFA, 4);
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      issue(4'd3, 32'd100, 32'd7);
      wait_done();
      repeat (12) @(negedge clk);
      check("ignored div no late busy", 64'(busy), 64'd0);
      check("ignored div no late hi", 64'(hi), 64'hFFFF_FFFF);
      check("ignored div no late lo", 64'(lo), 64'hFFFF_FFFA);

      issue(4'd15, 32'h5555_5555, 32'h3);
      check("op15 busy", 64'(busy), 64'd0);
      check("op15 hi/lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      issue(4'd0, 32'h5555_5555, 32'h3);
      check("nop busy", 64'(busy), 64'd0);
      check("nop hi/lo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

      issue(4'd5, 32'h0, 32'd0);
      issue(4'd6, 32'hFFFF_FFFF, 32'd0);
`ifdef MDU_MADD_EN
      expect_result("maddu carry", 32'd1, 32'd0, 5);
      issue(4'd8, 32'd1, 32'd1);
      wait_done();
      expect_result("madd -2*3", 32'h0000_0000, 32'hFFFF_FFFA, 5);
      issue(4'd7, 32'hFFFF_FFFE, 32'd3);
      wait_done();
`else
      issue(4'd8, 32'd1, 32'd1);
      check("maddu disabled busy", 64'(busy), 64'd0);
      repeat (6) @(negedge clk);
      check("maddu disabled hi/lo", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
      issue(4'd7, 32'd1, 32'd1);
      check("madd disabled busy", 64'(busy), 64'd0);
`endif

      issue(4'd5, 32'hABCD, 32'd0);
      issue(4'd1, 32'hFFFF_FFFE, 32'd3);
      @(negedge clk);
      check("pre-reset busy", 64'(busy), 64'd1);
      #2 reset = 1'b0;
      #1;
      check("async reset hi", 64'(hi), 64'd0);
      check("async reset lo", 64'(lo), 64'd0);
      check("async reset busy", 64'(busy), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (8) @(negedge clk);
      check("post-reset busy", 64'(busy), 64'd0);
      check("post-reset no commit", {hi, lo}, 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, alongside the single-cycle ALU.
- Consumes the same forwarded operands A/B and owns the HI/LO architectural registers.
- Drives `busy` back to the hazard/stall unit so that MDU-dependent instructions stall in D while an operation runs.
- MFHI/MFLO read the `hi`/`lo` outputs directly.

Parameters:
- MULT_CYCLES, 5, cycles from accepted MULT/MULTU (and MADD/MADDU) start to HI/LO update; legal range 1..255.
- DIV_CYCLES, 10, cycles from accepted DIV/DIVU start to HI/LO update; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset; clears all state while 0
- start  input  1  one-cycle request; `op` is valid with it
- op  input  4  operation: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU
- A  input  32  rs operand, after forwarding
- B  input  32  rt operand, after forwarding
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (reset==0, asynchronous):
  - hi=0, lo=0, busy=0, counter=0, state=IDLE.
  - Any in-flight operation is discarded; HI/LO are not written.
- State machine: IDLE, RUN.
- IDLE:
  - start with op 1-4 or 7-8 latches the 64-bit result in an internal register. Operands are sampled this cycle only.
  - The counter loads MULT_CYCLES (ops 1,2,7,8) or DIV_CYCLES (ops 3,4).
  - Next state is RUN; busy=1 from the next cycle.
- MTHI/MTLO (op 5/6) with start in IDLE:
  - hi<=A or lo<=A at this edge; no busy.
  - Ignored while busy.
- RUN:
  - Counter decrements each cycle.
  - On the edge where the counter reaches 1: the result is committed to {hi,lo}, busy drops to 0, and the state returns to IDLE.
  - Visible latency: busy is high for exactly N cycles; the new hi/lo is visible in the cycle busy first reads 0.
- start during RUN is ignored. The stall unit guarantees this never happens; the verification engineer still checks that it is ignored.
- op 0, or op>8, with start: no effect.
- MULT: signed 32x32 -> 64; hi=upper, lo=lower.
- MULTU: unsigned 32x32 -> 64.
- DIV: signed; lo=quotient truncated toward zero, hi=remainder with the sign of the dividend.
- DIVU: unsigned quotient/remainder.
- Division by zero (B==0): runs the full DIV_CYCLES with busy, then leaves hi/lo unchanged.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MADD: {hi,lo} at commit = {hi,lo} at start + signed A*B, wrapping at 64 bits.
- MADDU: same as MADD with the unsigned product.
  - hi/lo are frozen during RUN because only the MDU writes them, so the start-time value equals the commit-time value.
- hi/lo change only on:
  - the RUN commit edge,
  - an MTHI/MTLO edge,
  - reset.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 7 (MADD) and 8 (MADDU) are supported as described above.
- Undefined:
  - ops 7/8 are treated as NOP: no busy, hi/lo unchanged.
  - The 64-bit accumulate adder is not built.

Test Plan:
- reset=0 mid-run: MULT in flight, reset pulse -> hi=lo=0 and busy=0 immediately (asynchronous). After release, no late commit occurs.
- MULT A=0xFFFFFFFE (-2), B=3 -> busy high for exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU of the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- DIV A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles, then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU A=7, B=0 with prior hi=0x11, lo=0x22 -> busy for 10 cycles, then hi=0x11, lo=0x22 unchanged.
- MTHI A=0x1234 in IDLE -> hi=0x1234 next edge with busy=0. A second start (DIV) issued while a MULT is busy -> ignored; the MULT result is committed and busy is not extended.
- With MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, MADDU A=1, B=1 -> hi=1, lo=0 after 5 cycles. Without the macro: same stimulus -> busy stays 0 and hi/lo are unchanged.
